// File: rtl/rco_cal_pkg.sv
// Shared types and helpers for the RCO calibration controller.
package rco_cal_pkg;

  localparam int unsigned CW_W_DEF  = 7;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEAS,
    DECIDE,
    DONE
  } cal_state_t;

  // Increment that sticks at the all-ones value of a 'width'-bit field
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/rco_edge_counter.sv
// Brings rco_clk into the clk domain, detects rising edges and counts them
// over a measurement window. The count saturates instead of wrapping.
module rco_edge_counter
  import rco_cal_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rco_clk,
  input  logic             win_clr,
  input  logic             win_en,
  output logic [CNT_W-1:0] cnt
);

  logic s1, s2, s3;
  logic rise;

  // Two-flop synchronizer followed by one delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rco_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Window edge counter: cleared at window start, saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (win_clr) begin
      cnt <= '0;
    end else if (win_en && rise) begin
      cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
    end
  end

endmodule

// File: rtl/rco_calib_ctrl.sv
// RCO calibration controller: successive-approximation search on calib_word,
// judging each trial by the RCO edge count over a fixed window.
// Optional feature macro: RCO_CAL_MONITOR_EN (continuous post-lock frequency
// monitor driving freq_err); without it DONE is static and freq_err is 0.
module rco_calib_ctrl
  import rco_cal_pkg::*;
#(
  parameter int unsigned CW_W       = CW_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned WIN_CYC    = 2000,
  parameter int unsigned SETTLE_CYC = 1200,
  parameter int unsigned TOL        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cal_start,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic             rco_clk,
  output logic             rco_clk_en,
  output logic [CW_W-1:0]  calib_word,
  output logic             cal_busy,
  output logic             cal_done,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             freq_err
);

  localparam int unsigned TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned BIT_W   = (CW_W > 1) ? $clog2(CW_W) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_TOP     = BIT_W'(CW_W - 1);
  localparam logic [CW_W-1:0]  MSB_MASK    = CW_W'(1) << (CW_W - 1);

  cal_state_t       state;
  logic [TMR_W-1:0] tmr;
  logic [BIT_W-1:0] bit_idx;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] win_cnt;
  logic             settle_end, win_end;
  logic             win_clr, win_en;
  logic             too_fast, start_ok;
  logic [CW_W-1:0]  bit_mask, next_mask, cw_decided;

`ifdef RCO_CAL_MONITOR_EN
  logic             mon_mode;
  logic [CNT_W-1:0] abs_err;
  logic             out_of_tol;
`else
  assign freq_err = 1'b0;
`endif

  rco_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .rco_clk (rco_clk),
    .win_clr (win_clr),
    .win_en  (win_en),
    .cnt     (win_cnt)
  );

  // Timer terminal counts, window control and the SAR trial decision
  always_comb begin
    settle_end = (state == SETTLE) && (tmr == SETTLE_LAST);
    win_end    = (state == MEAS) && (tmr == WIN_LAST);
    win_clr    = settle_end;
    win_en     = (state == MEAS);
    too_fast   = meas_cnt > tgt;
    bit_mask   = CW_W'(1) << bit_idx;
    next_mask  = bit_mask >> 1;
    // Keep the trial bit when too fast, otherwise drop it; then arm the next bit
    cw_decided = (too_fast ? calib_word : (calib_word & ~bit_mask)) | next_mask;
`ifdef RCO_CAL_MONITOR_EN
    abs_err    = too_fast ? (meas_cnt - tgt) : (tgt - meas_cnt);
    out_of_tol = abs_err > CNT_W'(TOL);
    start_ok   = cal_start && ((state == IDLE) || (state == DONE) || mon_mode);
`else
    start_ok   = cal_start && ((state == IDLE) || (state == DONE));
`endif
  end

  // Calibration FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmr        <= '0;
      bit_idx    <= '0;
      tgt        <= '0;
      rco_clk_en <= 1'b0;
      calib_word <= '0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      meas_cnt   <= '0;
`ifdef RCO_CAL_MONITOR_EN
      mon_mode   <= 1'b0;
      freq_err   <= 1'b0;
`endif
    end else if (start_ok) begin
      state      <= SETTLE;
      tmr        <= '0;
      bit_idx    <= BIT_TOP;
      tgt        <= target_cnt;
      rco_clk_en <= 1'b1;
      calib_word <= MSB_MASK;
      cal_busy   <= 1'b1;
      cal_done   <= 1'b0;
`ifdef RCO_CAL_MONITOR_EN
      mon_mode   <= 1'b0;
      freq_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: ;
        SETTLE: begin
          if (settle_end) begin
            state <= MEAS;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        MEAS: begin
          if (win_end) begin
            meas_cnt <= win_cnt;
            state    <= DECIDE;
            tmr      <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DECIDE: begin
`ifdef RCO_CAL_MONITOR_EN
          // Post-lock windows reuse SETTLE/MEAS; only the error flag updates here
          if (mon_mode) begin
            freq_err <= out_of_tol;
            state    <= SETTLE;
          end else
`endif
          if (bit_idx == '0) begin
            calib_word <= cw_decided;
            state      <= DONE;
            cal_busy   <= 1'b0;
            cal_done   <= 1'b1;
`ifdef RCO_CAL_MONITOR_EN
            mon_mode   <= 1'b1;
`endif
          end else begin
            calib_word <= cw_decided;
            bit_idx    <= bit_idx - 1'b1;
            state      <= SETTLE;
          end
        end
        DONE: begin
`ifdef RCO_CAL_MONITOR_EN
          state <= SETTLE;
          tmr   <= '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rco_calib_ctrl.sv
// Scoreboard bench for rco_calib_ctrl with a behavioural RCO model.
// Window/settle lengths are shortened; targets are scaled to the 5 us window
// (count ~= 50 + (128-cw)*1.6), so target 150 -> cw 66, target 100 -> cw 97.
`timescale 1ns/1ps
module tb_rco_calib_ctrl;

  localparam int unsigned CW_W   = 7;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SETTLE = 250;
  localparam int unsigned WIN    = 1000;
  localparam int unsigned TOL    = 2;
  localparam int          TRIAL  = SETTLE + WIN + 1;
  localparam int          LAT    = CW_W * TRIAL + 1;

  typedef struct {
    int lo;
    int hi;
    int start_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cal_start = 1'b0;
  logic [CNT_W-1:0] target_cnt = '0;
  logic             rco_clk = 1'b0;
  logic             rco_clk_en;
  logic [CW_W-1:0]  calib_word;
  logic             cal_busy;
  logic             cal_done;
  logic [CNT_W-1:0] meas_cnt;
  logic             freq_err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  real  f_off = 0.0;
  exp_t sb_q[$];

  rco_calib_ctrl #(
    .CW_W       (CW_W),
    .CNT_W      (CNT_W),
    .WIN_CYC    (WIN),
    .SETTLE_CYC (SETTLE),
    .TOL        (TOL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cal_start  (cal_start),
    .target_cnt (target_cnt),
    .rco_clk    (rco_clk),
    .rco_clk_en (rco_clk_en),
    .calib_word (calib_word),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .meas_cnt   (meas_cnt),
    .freq_err   (freq_err)
  );

  always #2.5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RCO: 1 us start-up after enable, then f = 10 MHz + (128-cw)*41/128 MHz
  initial begin : rco_model
    real f;
    forever begin
      rco_clk = 1'b0;
      wait (rco_clk_en === 1'b1);
      #1000;
      while (rco_clk_en === 1'b1) begin
        f = 10.0 + real'(128 - int'(calib_word)) * 41.0 / 128.0 + f_off;
        #(500.0 / f);
        rco_clk = ~rco_clk;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic do_start(input int tgt, input int lo, input int hi, input bit expect_done);
    exp_t e;
    @(negedge clk);
    target_cnt = CNT_W'(tgt);
    cal_start  = 1'b1;
    if (expect_done) begin
      e.lo = lo;
      e.hi = hi;
      e.start_cyc = cyc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < LAT + 200; i++) begin
      @(negedge clk);
      if (cal_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: cal_done=0 expected 1 within %0d cycles", name, LAT + 200);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rco_clk_en"}, int'(rco_clk_en), 0);
    chk({tag, "_calib_word"}, int'(calib_word), 0);
    chk({tag, "_cal_busy"},   int'(cal_busy), 0);
    chk({tag, "_cal_done"},   int'(cal_done), 0);
    chk({tag, "_meas_cnt"},   int'(meas_cnt), 0);
    chk({tag, "_freq_err"},   int'(freq_err), 0);
  endtask

  // Monitor: on every rising cal_done, pop the expected result and compare
  initial begin : sb_monitor
    logic prev_done;
    logic prev_busy;
    exp_t e;
    prev_done = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (cal_done && !prev_done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: cal_done=1 with no calibration pending");
        end else begin
          e = sb_q.pop_front();
          chk_rng("result_calib_word", int'(calib_word), e.lo, e.hi);
          chk("done_latency", cyc - e.start_cyc, LAT);
          chk("en_at_done", int'(rco_clk_en), 1);
          chk("busy_at_done", int'(cal_busy), 0);
          chk("busy_before_done", int'(prev_busy), 1);
        end
      end
      prev_done = cal_done;
      prev_busy = cal_busy;
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", int'(cal_busy), 0);

    // Lock to target 150; a second start 500 cycles in (with a changed target) is ignored
    do_start(150, 65, 67, 1'b1);
    chk("start_busy", int'(cal_busy), 1);
    chk("start_en", int'(rco_clk_en), 1);
    chk("start_cw_msb", int'(calib_word), 64);
    repeat (499) @(negedge clk);
    target_cnt = '0;
    cal_start  = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    chk("ignored_start_busy", int'(cal_busy), 1);
    wait_done("lock150");

    // Extreme targets: always too fast, never too fast
    do_start(0, 127, 127, 1'b1);
    wait_done("tgt_zero");
    do_start(65535, 0, 0, 1'b1);
    wait_done("tgt_max");

    // Restart from DONE with a new target
    do_start(100, 95, 97, 1'b1);
    chk("restart_done_clr", int'(cal_done), 0);
    chk("restart_busy", int'(cal_busy), 1);
    chk("restart_cw_msb", int'(calib_word), 64);
    wait_done("lock100");

    // Reset during the third measurement window, then recalibrate
    do_start(150, 0, 0, 1'b0);
    repeat (2 * TRIAL + SETTLE + 100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    chk("midreset_hold_busy", int'(cal_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_start(150, 65, 67, 1'b1);
    wait_done("relock150");

`ifdef RCO_CAL_MONITOR_EN
    repeat (2 * TRIAL) @(negedge clk);
    chk("mon_locked_err", int'(freq_err), 0);
    f_off = 1.0;
    repeat (2 * TRIAL + 10) @(negedge clk);
    chk("mon_shift_err", int'(freq_err), 1);
    f_off = 0.0;
    repeat (2 * TRIAL + 10) @(negedge clk);
    chk("mon_restore_err", int'(freq_err), 0);
    chk_rng("mon_cw_held", int'(calib_word), 65, 67);
`endif

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
